// File: rtl/rf_wb_scheduler_pkg.sv
// lemonpc_pkg: shared constants and types for the LemonPC register-file writeback path
package lemonpc_pkg;
   localparam int DEF_ADDR_WIDTH = 5;
   localparam int DEF_DATA_WIDTH = 64;
   localparam int WB_SRC_EXU     = 0;
   localparam int WB_SRC_LSU     = 1;
   typedef enum logic {
      PRIO_EXU = 1'b0,
      PRIO_LSU = 1'b1
   } prio_e;
endpackage

// File: rtl/rf_wb_scheduler_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; priority flips only after a contested grant
module rr_arb2
   import lemonpc_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] i_req,
   output logic [1:0] o_gnt
);
   prio_e r_prio;
   // lone requester always wins; on contention the prio side wins
   always_comb begin
      o_gnt             = 2'b00;
      o_gnt[WB_SRC_EXU] = i_req[WB_SRC_EXU] & (!i_req[WB_SRC_LSU] | (r_prio == PRIO_EXU));
      o_gnt[WB_SRC_LSU] = i_req[WB_SRC_LSU] & (!i_req[WB_SRC_EXU] | (r_prio == PRIO_LSU));
   end
   // hand priority to the loser of a contested cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_prio <= PRIO_EXU;
      else if (&i_req)
         r_prio <= (r_prio == PRIO_EXU) ? PRIO_LSU : PRIO_EXU;
   end
endmodule

// File: rtl/rf_wb_scheduler.sv
// rf_wb_scheduler: register-file write-port arbiter plus busy scoreboard for issue hazards
module rf_wb_scheduler
   import lemonpc_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_iss_valid,
   output logic                  o_iss_ready,
   input  logic [ADDR_WIDTH-1:0] i_iss_rs1,
   input  logic [ADDR_WIDTH-1:0] i_iss_rs2,
   input  logic [ADDR_WIDTH-1:0] i_iss_rd,
   input  logic                  i_iss_rd_en,
   input  logic                  i_exu_wb_valid,
   output logic                  o_exu_wb_ready,
   input  logic [ADDR_WIDTH-1:0] i_exu_wb_rd,
   input  logic [DATA_WIDTH-1:0] i_exu_wb_data,
   input  logic                  i_lsu_wb_valid,
   output logic                  o_lsu_wb_ready,
   input  logic [ADDR_WIDTH-1:0] i_lsu_wb_rd,
   input  logic [DATA_WIDTH-1:0] i_lsu_wb_data,
   output logic                  o_rf_wen,
   output logic [ADDR_WIDTH-1:0] o_rf_rd,
   output logic [DATA_WIDTH-1:0] o_rf_data_d,
   output logic [ADDR_WIDTH:0]   o_pending,
   output logic                  o_idle,
   output logic                  o_err
);
   localparam int NREG = 2 ** ADDR_WIDTH;

   logic [NREG-1:0]       r_busy;
   logic [ADDR_WIDTH:0]   r_pending;
   logic                  r_rf_wen;
   logic [ADDR_WIDTH-1:0] r_rf_rd;
   logic [DATA_WIDTH-1:0] r_rf_data;
   logic                  r_err;

   logic [1:0]            w_gnt;
   logic [ADDR_WIDTH-1:0] w_win_rd;
   logic [DATA_WIDTH-1:0] w_win_data;
   logic                  w_fire;
   logic                  w_clr;
   logic                  w_spur;
   logic [NREG-1:0]       w_busy_nxt;
   logic [ADDR_WIDTH:0]   w_pending_nxt;

   rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .i_req ({i_lsu_wb_valid, i_exu_wb_valid}),
      .o_gnt (w_gnt)
   );

   // hazard check, winner mux and next scoreboard state
   always_comb begin
      o_iss_ready   = !(r_busy[i_iss_rs1] | r_busy[i_iss_rs2] | (i_iss_rd_en & r_busy[i_iss_rd]));
      w_fire        = i_iss_valid & o_iss_ready & i_iss_rd_en & (i_iss_rd != '0);
      w_clr         = r_rf_wen & r_busy[r_rf_rd];
      w_spur        = r_rf_wen & !r_busy[r_rf_rd];
      w_win_rd      = w_gnt[WB_SRC_LSU] ? i_lsu_wb_rd : i_exu_wb_rd;
      w_win_data    = w_gnt[WB_SRC_LSU] ? i_lsu_wb_data : i_exu_wb_data;
      w_busy_nxt    = r_busy;
      if (w_fire)
         w_busy_nxt[i_iss_rd] = 1'b1;
      if (w_clr)
         w_busy_nxt[r_rf_rd] = 1'b0;
      w_busy_nxt[0] = 1'b0;
      w_pending_nxt = r_pending + {{ADDR_WIDTH{1'b0}}, w_fire} - {{ADDR_WIDTH{1'b0}}, w_clr};
   end

   // scoreboard, counter, write stage and sticky error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy    <= '0;
         r_pending <= '0;
         r_rf_wen  <= 1'b0;
         r_rf_rd   <= '0;
         r_rf_data <= '0;
         r_err     <= 1'b0;
      end else begin
         r_busy    <= w_busy_nxt;
         r_pending <= w_pending_nxt;
         r_rf_wen  <= (|w_gnt) & (w_win_rd != '0);
         if (|w_gnt) begin
            r_rf_rd   <= w_win_rd;
            r_rf_data <= w_win_data;
         end
         if (w_spur)
            r_err <= 1'b1;
      end
   end

   assign o_exu_wb_ready = w_gnt[WB_SRC_EXU];
   assign o_lsu_wb_ready = w_gnt[WB_SRC_LSU];
   assign o_rf_wen       = r_rf_wen;
   assign o_rf_rd        = r_rf_rd;
   assign o_rf_data_d    = r_rf_data;
   assign o_pending      = r_pending;
   assign o_idle         = (r_pending == '0) & !r_rf_wen;
   assign o_err          = r_err;
endmodule

// File: tb/tb_rf_wb_scheduler.sv
// tb_rf_wb_scheduler: vector table for issue gating, scoreboard queue for writes, sequences for timing corners
module tb_rf_wb_scheduler;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_iss_valid, o_iss_ready, i_iss_rd_en;
   logic [4:0]  i_iss_rs1, i_iss_rs2, i_iss_rd;
   logic        i_exu_wb_valid, o_exu_wb_ready, i_lsu_wb_valid, o_lsu_wb_ready;
   logic [4:0]  i_exu_wb_rd, i_lsu_wb_rd;
   logic [63:0] i_exu_wb_data, i_lsu_wb_data;
   logic        o_rf_wen, o_idle, o_err;
   logic [4:0]  o_rf_rd;
   logic [63:0] o_rf_data_d;
   logic [5:0]  o_pending;

   typedef struct {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic       rd_en;
      logic       exp_ready;
   } vec_t;
   typedef struct {
      logic [4:0]  rd;
      logic [63:0] data;
   } wb_t;

   vec_t tbl[9];
   wb_t  q[$];
   logic m_prio = 1'b0;
   int   n_chk  = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   rf_wb_scheduler dut (
      .clk(clk), .rst_n(rst_n),
      .i_iss_valid(i_iss_valid), .o_iss_ready(o_iss_ready),
      .i_iss_rs1(i_iss_rs1), .i_iss_rs2(i_iss_rs2), .i_iss_rd(i_iss_rd), .i_iss_rd_en(i_iss_rd_en),
      .i_exu_wb_valid(i_exu_wb_valid), .o_exu_wb_ready(o_exu_wb_ready),
      .i_exu_wb_rd(i_exu_wb_rd), .i_exu_wb_data(i_exu_wb_data),
      .i_lsu_wb_valid(i_lsu_wb_valid), .o_lsu_wb_ready(o_lsu_wb_ready),
      .i_lsu_wb_rd(i_lsu_wb_rd), .i_lsu_wb_data(i_lsu_wb_data),
      .o_rf_wen(o_rf_wen), .o_rf_rd(o_rf_rd), .o_rf_data_d(o_rf_data_d),
      .o_pending(o_pending), .o_idle(o_idle), .o_err(o_err)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [4:0] rd);
      i_iss_valid = 1'b1; i_iss_rd_en = 1'b1; i_iss_rd = rd; i_iss_rs1 = '0; i_iss_rs2 = '0;
      #1;
      chk($sformatf("issue_ready_rd%0d", rd), o_iss_ready, 1'b1);
      tick;
      i_iss_valid = 1'b0; i_iss_rd_en = 1'b0;
   endtask

   task automatic wb(input logic ev, input logic [4:0] erd, input logic [63:0] ed,
                     input logic lv, input logic [4:0] lrd, input logic [63:0] ld);
      logic eg, lg;
      i_exu_wb_valid = ev; i_exu_wb_rd = erd; i_exu_wb_data = ed;
      i_lsu_wb_valid = lv; i_lsu_wb_rd = lrd; i_lsu_wb_data = ld;
      #1;
      eg = ev & (!lv | !m_prio);
      lg = lv & (!ev | m_prio);
      chk("exu_ready", o_exu_wb_ready, eg);
      chk("lsu_ready", o_lsu_wb_ready, lg);
      if (eg && erd != 0) q.push_back('{erd, ed});
      if (lg && lrd != 0) q.push_back('{lrd, ld});
      if (ev && lv) m_prio = ~m_prio;
      tick;
      i_exu_wb_valid = 1'b0; i_lsu_wb_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1 && o_rf_wen === 1'b1) begin
         if (q.size() == 0) chk("wen_unexpected", 1'b1, 1'b0);
         else begin
            wb_t e;
            e = q.pop_front();
            chk("rf_rd", o_rf_rd, e.rd);
            chk("rf_data", o_rf_data_d, e.data);
         end
      end
   end

   initial begin
      tbl[0] = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b1};
      tbl[1] = '{5'd3,  5'd0,  5'd0,  1'b0, 1'b0};
      tbl[2] = '{5'd0,  5'd9,  5'd0,  1'b0, 1'b0};
      tbl[3] = '{5'd4,  5'd5,  5'd0,  1'b0, 1'b1};
      tbl[4] = '{5'd4,  5'd5,  5'd9,  1'b1, 1'b0};
      tbl[5] = '{5'd4,  5'd5,  5'd9,  1'b0, 1'b1};
      tbl[6] = '{5'd1,  5'd2,  5'd3,  1'b1, 1'b0};
      tbl[7] = '{5'd0,  5'd0,  5'd0,  1'b1, 1'b1};
      tbl[8] = '{5'd31, 5'd30, 5'd10, 1'b1, 1'b1};

      rst_n = 1'b0;
      i_iss_valid = 0; i_iss_rd_en = 0; i_iss_rs1 = 0; i_iss_rs2 = 0; i_iss_rd = 0;
      i_exu_wb_valid = 0; i_exu_wb_rd = 0; i_exu_wb_data = 0;
      i_lsu_wb_valid = 0; i_lsu_wb_rd = 0; i_lsu_wb_data = 0;
      #3;
      chk("rst_wen", o_rf_wen, 1'b0);
      chk("rst_pending", o_pending, 6'd0);
      chk("rst_idle", o_idle, 1'b1);
      chk("rst_err", o_err, 1'b0);
      tick; tick;
      rst_n = 1'b1;
      tick;

      issue(5'd3);
      issue(5'd9);
      chk("pending_2", o_pending, 6'd2);
      for (int i = 0; i < 9; i++) begin
         i_iss_rs1 = tbl[i].rs1; i_iss_rs2 = tbl[i].rs2; i_iss_rd = tbl[i].rd; i_iss_rd_en = tbl[i].rd_en;
         #1;
         chk($sformatf("tbl%0d_ready", i), o_iss_ready, tbl[i].exp_ready);
      end
      i_iss_rd_en = 1'b0; i_iss_rs1 = 0; i_iss_rs2 = 0; i_iss_rd = 0;
      tick;

      wb(1'b1, 5'd3, 64'h3333, 1'b1, 5'd9, 64'h9999);
      wb(1'b0, 5'd0, 64'h0,    1'b1, 5'd9, 64'h9999);
      tick; tick;
      chk("rr1_pending", o_pending, 6'd0);
      issue(5'd1);
      issue(5'd2);
      wb(1'b1, 5'd1, 64'h1111, 1'b1, 5'd2, 64'h2222);
      wb(1'b1, 5'd1, 64'h1111, 1'b0, 5'd0, 64'h0);
      tick; tick;
      chk("rr2_pending", o_pending, 6'd0);

      issue(5'd5);
      i_iss_valid = 1'b1; i_iss_rs1 = 5'd5; i_iss_rs2 = 5'd0; i_iss_rd_en = 1'b0;
      #1; chk("raw_c1", o_iss_ready, 1'b0); tick;
      chk("raw_c2", o_iss_ready, 1'b0); tick;
      chk("raw_c3", o_iss_ready, 1'b0);
      wb(1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 64'h0);
      chk("raw_c4_wen", o_rf_wen, 1'b1);
      chk("raw_c4_rd", o_rf_rd, 5'd5);
      chk("raw_c4_ready", o_iss_ready, 1'b0);
      tick;
      chk("raw_c5_ready", o_iss_ready, 1'b1);
      chk("raw_pending", o_pending, 6'd0);
      i_iss_valid = 1'b0; i_iss_rs1 = 0;

      issue(5'd0);
      chk("x0_pending", o_pending, 6'd0);
      wb(1'b1, 5'd0, 64'hdead, 1'b0, 5'd0, 64'h0);
      chk("x0_wen", o_rf_wen, 1'b0);
      tick;
      chk("x0_err", o_err, 1'b0);

      wb(1'b0, 5'd0, 64'h0, 1'b1, 5'd7, 64'h7777);
      chk("spur_wen", o_rf_wen, 1'b1);
      chk("spur_err_early", o_err, 1'b0);
      tick;
      chk("spur_err", o_err, 1'b1);
      chk("spur_pending", o_pending, 6'd0);
      tick;
      chk("spur_err_sticky", o_err, 1'b1);

      issue(5'd4);
      wb(1'b1, 5'd4, 64'h4444, 1'b0, 5'd0, 64'h0);
      chk("mid_wen_pre", o_rf_wen, 1'b1);
      rst_n = 1'b0;
      q.delete();
      m_prio = 1'b0;
      #1;
      chk("mid_rst_wen", o_rf_wen, 1'b0);
      chk("mid_rst_pending", o_pending, 6'd0);
      chk("mid_rst_idle", o_idle, 1'b1);
      chk("mid_rst_err", o_err, 1'b0);
      tick;
      rst_n = 1'b1;
      i_iss_rs1 = 5'd4; i_iss_rs2 = 5'd5; i_iss_rd = 5'd4; i_iss_rd_en = 1'b1;
      #1;
      chk("post_rst_ready", o_iss_ready, 1'b1);
      i_iss_rd_en = 1'b0;
      tick;

      for (int r = 1; r < 32; r++) issue(5'(r));
      chk("full_pending", o_pending, 6'd31);
      i_iss_rd = 5'd31; i_iss_rd_en = 1'b1;
      #1;
      chk("full_waw", o_iss_ready, 1'b0);
      i_iss_rd_en = 1'b0;
      for (int r = 1; r < 32; r++) begin
         logic [63:0] d;
         d = 64'hA5A5_0000_0000_0000 | 64'(r);
         if (r % 2 == 1) wb(1'b1, 5'(r), d, 1'b0, 5'd0, 64'h0);
         else            wb(1'b0, 5'd0, 64'h0, 1'b1, 5'(r), d);
      end
      tick; tick;
      chk("drain_pending", o_pending, 6'd0);
      chk("drain_idle", o_idle, 1'b1);
      chk("drain_err", o_err, 1'b0);
      chk("queue_empty", 64'(q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
